// File: rtl/nonogram_load_sequencer_if.sv
// Constraint-BRAM read port and constraint-word stream between the load sequencer and its peers.
// The sequencer drives through master; the BRAM/solver/display side uses slave.
interface nonogram_load_sequencer_if #(
  parameter int ADDR_W = 7,
  parameter int CONS_W = 20
);
  logic              mem_rd_en;
  logic [ADDR_W-1:0] mem_addr;
  logic [CONS_W-1:0] mem_data;
  logic              cons_valid;
  logic [4:0]        cons_idx;
  logic [CONS_W-1:0] cons_data;
  logic              cons_ready;

  modport master (
    output mem_rd_en, mem_addr, cons_valid, cons_idx, cons_data,
    input  mem_data, cons_ready
  );

  modport slave (
    input  mem_rd_en, mem_addr, cons_valid, cons_idx, cons_data,
    output mem_data, cons_ready
  );
endinterface

// File: rtl/nonogram_load_sequencer.sv
// Loads one puzzle's constraint words from BRAM, streams them to the solver/display,
// then runs the solver and captures its grid or records fail/timeout.
//
// state      | meaning
// IDLE       | waiting for start after reset
// RD_ISSUE   | one-cycle BRAM read strobe for word idx
// RD_WAIT    | waiting RD_LAT cycles for BRAM data
// PRESENT    | cons_valid high until the sink accepts the word
// SOLVE_GO   | one-cycle solver_start pulse
// SOLVE_WAIT | waiting for done/fail or budget expiry
// DONE       | grid captured, waiting for start
// ERR        | err_code set, waiting for start
module nonogram_load_sequencer #(
  parameter int NUM_CONS = 20,
  parameter int CONS_W   = 20,
  parameter int GRID_N   = 10,
  parameter int RD_LAT   = 2,
  parameter int ADDR_W   = 7,
  parameter int TIMEOUT  = 2**24
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic                       start_i,
  input  logic [1:0]                 puzzle_sel_i,
  nonogram_load_sequencer_if.master  bus,
  output logic                       solver_start_o,
  input  logic                       solver_done_i,
  input  logic                       solver_fail_i,
  input  logic [GRID_N*GRID_N-1:0]   grid_i,
  output logic [GRID_N*GRID_N-1:0]   grid_o,
  output logic                       disp_update_o,
  output logic                       busy_o,
  output logic [1:0]                 err_code_o
);
  localparam int LAT_W = $clog2(RD_LAT + 1);
  localparam int CNT_W = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;

  typedef enum logic [2:0] {
    S_IDLE, S_RD_ISSUE, S_RD_WAIT, S_PRESENT,
    S_SOLVE_GO, S_SOLVE_WAIT, S_DONE, S_ERR
  } state_t;

  state_t                    state_q, state_d;
  logic [ADDR_W-1:0]         base_q, base_d;
  logic [4:0]                idx_q, idx_d;
  logic [LAT_W-1:0]          lat_q, lat_d;
  logic [CNT_W-1:0]          cnt_q, cnt_d;
  logic [CONS_W-1:0]         cons_data_q, cons_data_d;
  logic [GRID_N*GRID_N-1:0]  grid_q, grid_d;
  logic                      disp_q, disp_d;
  logic [1:0]                err_q, err_d;

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q     <= S_IDLE;
      base_q      <= '0;
      idx_q       <= '0;
      lat_q       <= '0;
      cnt_q       <= '0;
      cons_data_q <= '0;
      grid_q      <= '0;
      disp_q      <= 1'b0;
      err_q       <= 2'd0;
    end else begin
      state_q     <= state_d;
      base_q      <= base_d;
      idx_q       <= idx_d;
      lat_q       <= lat_d;
      cnt_q       <= cnt_d;
      cons_data_q <= cons_data_d;
      grid_q      <= grid_d;
      disp_q      <= disp_d;
      err_q       <= err_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    base_d      = base_q;
    idx_d       = idx_q;
    lat_d       = lat_q;
    cnt_d       = cnt_q;
    cons_data_d = cons_data_q;
    grid_d      = grid_q;
    disp_d      = 1'b0;
    err_d       = err_q;
    case (state_q)
      S_IDLE, S_DONE, S_ERR: begin
        if (start_i) begin
          base_d  = ADDR_W'({puzzle_sel_i, 5'b0});
          idx_d   = '0;
          err_d   = 2'd0;
          state_d = S_RD_ISSUE;
        end
      end
      S_RD_ISSUE: begin
        lat_d   = LAT_W'(1);
        state_d = S_RD_WAIT;
      end
      S_RD_WAIT: begin
        if (lat_q == LAT_W'(RD_LAT)) begin
          cons_data_d = bus.mem_data;
          state_d     = S_PRESENT;
        end else begin
          lat_d = lat_q + LAT_W'(1);
        end
      end
      S_PRESENT: begin
        if (bus.cons_ready) begin
          if (idx_q == 5'(NUM_CONS - 1)) begin
            state_d = S_SOLVE_GO;
          end else begin
            idx_d   = idx_q + 5'd1;
            state_d = S_RD_ISSUE;
          end
        end
      end
      S_SOLVE_GO: begin
        // cnt_q counts cycles elapsed since the solver_start cycle
        cnt_d   = CNT_W'(1);
        state_d = S_SOLVE_WAIT;
      end
      S_SOLVE_WAIT: begin
        if (solver_fail_i) begin
          err_d   = 2'd1;
          state_d = S_ERR;
        end else if (solver_done_i) begin
          grid_d  = grid_i;
          disp_d  = 1'b1;
          state_d = S_DONE;
        end else if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
          err_d   = 2'd2;
          state_d = S_ERR;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    bus.mem_rd_en  = (state_q == S_RD_ISSUE);
    bus.mem_addr   = (state_q == S_RD_ISSUE) ? base_q + ADDR_W'(idx_q) : '0;
    // drop valid in the very cycle reset is sampled so no word is half-delivered
    bus.cons_valid = (state_q == S_PRESENT) && !reset;
    bus.cons_idx   = idx_q;
    bus.cons_data  = cons_data_q;
    solver_start_o = (state_q == S_SOLVE_GO);
    busy_o         = !((state_q == S_IDLE) || (state_q == S_DONE) || (state_q == S_ERR));
    grid_o         = grid_q;
    disp_update_o  = disp_q;
    err_code_o     = err_q;
  end
endmodule
